// File: rtl/button_debouncer.sv
// button_debouncer
//
// Turns a bouncy, asynchronous push-button pin into clean signals that are
// synchronous to clk. The pin is optionally inverted, passed through a plain
// flip-flop synchronizer, then qualified by a four-state FSM. A change is
// accepted only after the synchronized level has held for DEBOUNCE_CYCLES.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   button       raw push-button pin, asynchronous to clk
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle strobe when a press is accepted
//   btn_release  one-cycle strobe when a release is accepted
//   btn_long     one-cycle strobe after LONG_PRESS_CYCLES of hold, once per press
//   press_count  accepted presses, wraps modulo 256
//   led_toggle   inverts on every accepted press
module button_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int ACTIVE_LOW        = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_count,
  output logic       led_toggle
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCW = $clog2(LONG_PRESS_CYCLES + 1);

  // Terminal counts; a counter equal to these on a cycle means the
  // required number of cycles has now elapsed.
  localparam logic [DCW-1:0] DLAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HLAST = HCW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } state_t;

  logic                   pinIn;
  logic [SYNC_STAGES-1:0] syncChain_q;
  logic [SYNC_STAGES-1:0] syncChain_d;
  logic                   syncPin;

  state_t                 state_q;
  logic [DCW-1:0]         dcnt_q;
  logic [HCW-1:0]         hcnt_q;
  logic                   longDone_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;
  logic                   long_q;
  logic [7:0]             pressCount_q;
  logic                   led_q;

  // Normalise polarity before synchronising so that everything downstream
  // sees 1 = pressed. The inversion sits ahead of the first flop so the
  // synchronizer chain itself is nothing but flops.
  assign pinIn       = (ACTIVE_LOW != 0) ? ~button : button;
  assign syncChain_d = {syncChain_q[SYNC_STAGES-2:0], pinIn};
  assign syncPin     = syncChain_q[SYNC_STAGES-1];

  // Synchronizer shift register. Resets to all zero, i.e. "released", so a
  // button held through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncChain_q <= '0;
    end else begin
      syncChain_q <= syncChain_d;
    end
  end

  // Debounce FSM. Both CHECK states count consecutive cycles of the new
  // level and fall straight back to the prior stable state on any
  // contrary sample, so qualification always restarts from zero. The hold
  // timer only advances in PRESSED (including the cycle that leaves it),
  // which means a rejected release bounce pauses it for exactly the time
  // spent in CHECK_RELEASE rather than restarting it. Strobes default low
  // every cycle so each lasts exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RELEASED;
      dcnt_q       <= '0;
      hcnt_q       <= '0;
      longDone_q   <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      pressCount_q <= 8'd0;
      led_q        <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (syncPin) begin
            state_q <= CHECK_PRESS;
            dcnt_q  <= '0;
          end
        end
        CHECK_PRESS: begin
          if (!syncPin) begin
            state_q <= RELEASED;
          end else if (dcnt_q == DLAST) begin
            state_q      <= PRESSED;
            level_q      <= 1'b1;
            press_q      <= 1'b1;
            pressCount_q <= pressCount_q + 8'd1;
            led_q        <= ~led_q;
            hcnt_q       <= '0;
            longDone_q   <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!syncPin) begin
            state_q <= CHECK_RELEASE;
            dcnt_q  <= '0;
          end
          if (!longDone_q) begin
            if (hcnt_q == HLAST) begin
              long_q     <= 1'b1;
              longDone_q <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
        end
        CHECK_RELEASE: begin
          if (syncPin) begin
            state_q <= PRESSED;
          end else if (dcnt_q == DLAST) begin
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RELEASED;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign press_count = pressCount_q;
  assign led_toggle  = led_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20. dut drives an active-high pin, dut2 the same block
// with ACTIVE_LOW=1 for the reset-while-held case.
//
// Timing model used for every expectation: a pin value applied before edge
// k reaches the FSM at edge k+2; a press or release qualifies four edges
// after that, so the strobe is visible just after edge k+6.
module tb_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic       btn_level;
  logic       btn_press;
  logic       btn_release;
  logic       btn_long;
  logic [7:0] press_count;
  logic       led_toggle;

  logic       rst2_n;
  logic       button2;
  logic       level2;
  logic       press2;
  logic       release2;
  logic       long2;
  logic [7:0] count2;
  logic       led2;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  int pressAt, longAt, releaseAt;
  int pressCnt, longCnt, releaseCnt;
  int press2At, press2Cnt;

  typedef struct {
    logic        btn;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[31];

  button_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .press_count(press_count), .led_toggle(led_toggle)
  );

  button_debouncer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .button(button2),
    .btn_level(level2), .btn_press(press2), .btn_release(release2),
    .btn_long(long2), .press_count(count2), .led_toggle(led2)
  );

  // Free-running 100 MHz-style clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic b, input logic lvl, input logic pr,
                                 input logic rl, input logic lg, input logic led,
                                 input logic [7:0] cnt);
    vec_t v;
    v.btn = b;
    v.exp = {lvl, pr, rl, lg, led, cnt};
    return v;
  endfunction

  function automatic logic [12:0] dutVec();
    return {btn_level, btn_press, btn_release, btn_long, led_toggle, press_count};
  endfunction

  function automatic logic [12:0] dut2Vec();
    return {level2, press2, release2, long2, led2, count2};
  endfunction

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance one clock and record strobe activity of both instances.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    if (btn_press) begin
      pressCnt++;
      if (pressAt < 0) pressAt = cyc;
    end
    if (btn_long) begin
      longCnt++;
      if (longAt < 0) longAt = cyc;
    end
    if (btn_release) begin
      releaseCnt++;
      if (releaseAt < 0) releaseAt = cyc;
    end
    if (press2) begin
      press2Cnt++;
      if (press2At < 0) press2At = cyc;
    end
  endtask

  task automatic applyStimulus(input logic b, input int n);
    button = b;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic clearEvents();
    pressAt = -1; longAt = -1; releaseAt = -1;
    pressCnt = 0; longCnt = 0; releaseCnt = 0;
    press2At = -1; press2Cnt = 0;
  endtask

  // Assert reset away from a clock edge, check the outputs cleared without
  // any edge, then release it mid-cycle.
  task automatic applyReset(input string name);
    button = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput(name, 32'(dutVec()), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int e;

    // Bounce then steady press, release, then a too-short press.
    vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[1]  = mkVec(0, 0, 0, 0, 0, 0, 8'd0);
    vecs[2]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[3]  = mkVec(0, 0, 0, 0, 0, 0, 8'd0);
    vecs[4]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[5]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[6]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[7]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[8]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[9]  = mkVec(1, 0, 0, 0, 0, 0, 8'd0);
    vecs[10] = mkVec(1, 1, 1, 0, 0, 1, 8'd1);
    vecs[11] = mkVec(1, 1, 0, 0, 0, 1, 8'd1);
    vecs[12] = mkVec(0, 1, 0, 0, 0, 1, 8'd1);
    vecs[13] = mkVec(0, 1, 0, 0, 0, 1, 8'd1);
    vecs[14] = mkVec(0, 1, 0, 0, 0, 1, 8'd1);
    vecs[15] = mkVec(0, 1, 0, 0, 0, 1, 8'd1);
    vecs[16] = mkVec(0, 1, 0, 0, 0, 1, 8'd1);
    vecs[17] = mkVec(0, 1, 0, 0, 0, 1, 8'd1);
    vecs[18] = mkVec(0, 0, 0, 1, 0, 1, 8'd1);
    vecs[19] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[20] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[21] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[22] = mkVec(1, 0, 0, 0, 0, 1, 8'd1);
    vecs[23] = mkVec(1, 0, 0, 0, 0, 1, 8'd1);
    vecs[24] = mkVec(1, 0, 0, 0, 0, 1, 8'd1);
    vecs[25] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[26] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[27] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[28] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[29] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);
    vecs[30] = mkVec(0, 0, 0, 0, 0, 1, 8'd1);

    rst_n   = 1'b1;
    rst2_n  = 1'b1;
    button  = 1'b0;
    button2 = 1'b1;
    clearEvents();
    #2;
    rst2_n = 1'b0;
    applyReset("reset_state");
    rst2_n = 1'b1;

    // Table-driven bounce, release and short-press sequence.
    for (int i = 0; i < 31; i++) begin
      button = vecs[i].btn;
      stepCycle();
      checkOutput($sformatf("vec%0d", i), 32'(dutVec()), 32'(vecs[i].exp));
    end

    // Clean press held past the long-press time, then release.
    applyReset("reset_t1");
    clearEvents();
    e = cyc + 1;
    applyStimulus(1'b1, 40);
    checkOutput("t1_level_held", 32'(btn_level), 32'd1);
    applyStimulus(1'b0, 10);
    checkOutput("t1_press_at", 32'(pressAt), 32'(e + 6));
    checkOutput("t1_long_at", 32'(longAt), 32'(e + 26));
    checkOutput("t1_release_at", 32'(releaseAt), 32'(e + 46));
    checkOutput("t1_strobe_counts", {8'd0, 8'(pressCnt), 8'(longCnt), 8'(releaseCnt)},
                32'h00010101);
    checkOutput("t1_count_led_level", {22'd0, btn_level, led_toggle, press_count},
                {22'd0, 1'b0, 1'b1, 8'd1});

    // Two-cycle release bounce while held: long strobe slips by two cycles.
    applyReset("reset_t4");
    clearEvents();
    e = cyc + 1;
    applyStimulus(1'b1, 15);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 30);
    checkOutput("t4_press_at", 32'(pressAt), 32'(e + 6));
    checkOutput("t4_long_at", 32'(longAt), 32'(e + 28));
    checkOutput("t4_no_release", 32'(releaseCnt), 32'd0);
    checkOutput("t4_level_held", 32'(btn_level), 32'd1);
    applyStimulus(1'b0, 10);
    checkOutput("t4_release_at", 32'(releaseAt), 32'(e + 53));
    checkOutput("t4_strobe_counts", {8'd0, 8'(pressCnt), 8'(longCnt), 8'(releaseCnt)},
                32'h00010101);

    // 257 clean presses: counter wraps through zero.
    applyReset("reset_t5");
    clearEvents();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 10);
    end
    checkOutput("t5_wrap_count_led", {23'd0, led_toggle, press_count}, 32'd0);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    checkOutput("t5_final_count_led", {23'd0, led_toggle, press_count},
                {23'd0, 1'b1, 8'd1});
    checkOutput("t5_press_strobes", 32'(pressCnt), 32'd257);
    checkOutput("t5_no_long", 32'(longCnt), 32'd0);

    // Active-low pin held pressed through a mid-press reset.
    clearEvents();
    button2 = 1'b0;
    e = cyc + 1;
    applyStimulus(1'b0, 8);
    checkOutput("t6_first_press_at", 32'(press2At), 32'(e + 6));
    checkOutput("t6_level_before_reset", {23'd0, level2, count2}, {23'd0, 1'b1, 8'd1});
    rst2_n = 1'b0;
    #1;
    checkOutput("t6_async_clear", 32'(dut2Vec()), 32'd0);
    applyStimulus(1'b0, 2);
    checkOutput("t6_held_in_reset", 32'(dut2Vec()), 32'd0);
    #2;
    rst2_n = 1'b1;
    clearEvents();
    e = cyc + 1;
    applyStimulus(1'b0, 10);
    checkOutput("t6_repress_at", 32'(press2At), 32'(e + 6));
    checkOutput("t6_repress_count", {23'd0, led2, count2}, {23'd0, 1'b1, 8'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
